complex_axpy_stream: RTL

COMPLEX_AXPY_STREAM -- requirements
Module: complex_axpy_stream

---
 rtl/caxpy_pkg.sv | 19 +
 rtl/caxpy_lane.sv | 104 ++++++++++
 rtl/complex_axpy_stream.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/caxpy_pkg.sv
// Shared widths, controller state encoding and complex-element layout for the
// complex AXPY streaming engine.
package caxpy_pkg;

  localparam int CAXPY_EW = 64;
  localparam int CAXPY_CW = CAXPY_EW / 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } caxpy_state_t;

  typedef struct packed {
    logic signed [CAXPY_CW-1:0] re;
    logic signed [CAXPY_CW-1:0] im;
  } caxpy_cplx_t;

endpackage

// File: rtl/caxpy_lane.sv
// One complex lane: y = v +/- conj?(x) * conj?(c), three pipeline stages.
// Final reduction saturates when CAXPY_SAT_EN is defined, otherwise wraps.
module caxpy_lane
  import caxpy_pkg::*;
#(
  parameter int EW   = CAXPY_EW,
  parameter int FRAC = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_op,
  input  logic          i_conj_x,
  input  logic          i_conj_c,
  input  logic          i_zero,
  input  logic [EW-1:0] i_x,
  input  logic [EW-1:0] i_c,
  input  logic [EW-1:0] i_v,
  output logic [EW-1:0] o_y
);

  localparam int CW = EW / 2;
  localparam int MW = 2 * CW;
  localparam int PW = 2 * CW + 1;
  localparam int SW = CW + 2;

`ifdef CAXPY_SAT_EN
  localparam logic signed [SW-1:0] HI = {3'b000, {(CW-1){1'b1}}};
  localparam logic signed [SW-1:0] LO = {3'b111, {(CW-1){1'b0}}};
`endif

  function automatic logic signed [CW-1:0] reduce_half(input logic signed [SW-1:0] s);
`ifdef CAXPY_SAT_EN
    if (s > HI) return HI[CW-1:0];
    if (s < LO) return LO[CW-1:0];
`endif
    return s[CW-1:0];
  endfunction

  logic signed [CW-1:0] w_xr, w_xi, w_cr, w_ci;
  assign w_xr = i_x[EW-1:CW];
  assign w_xi = i_x[CW-1:0];
  assign w_cr = i_c[EW-1:CW];
  assign w_ci = i_c[CW-1:0];

  // Stage p0: conjugated operands
  logic signed [CW-1:0] r_xr_p0, r_xi_p0, r_cr_p0, r_ci_p0, r_vr_p0, r_vi_p0;
  logic                 r_zero_p0;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_xr_p0   <= w_xr;
      r_xi_p0   <= i_conj_x ? -w_xi : w_xi;
      r_cr_p0   <= w_cr;
      r_ci_p0   <= i_conj_c ? -w_ci : w_ci;
      r_vr_p0   <= i_v[EW-1:CW];
      r_vi_p0   <= i_v[CW-1:0];
      r_zero_p0 <= i_zero;
    end
  end

  // Stage p1: full-precision complex product
  logic signed [MW-1:0] w_ac, w_bd, w_ad, w_bc;
  assign w_ac = MW'(r_xr_p0) * MW'(r_cr_p0);
  assign w_bd = MW'(r_xi_p0) * MW'(r_ci_p0);
  assign w_ad = MW'(r_xr_p0) * MW'(r_ci_p0);
  assign w_bc = MW'(r_xi_p0) * MW'(r_cr_p0);

  logic signed [PW-1:0] r_pr_p1, r_pi_p1;
  logic signed [CW-1:0] r_vr_p1, r_vi_p1;
  logic                 r_zero_p1;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_pr_p1   <= PW'(w_ac) - PW'(w_bd);
      r_pi_p1   <= PW'(w_ad) + PW'(w_bc);
      r_vr_p1   <= r_vr_p0;
      r_vi_p1   <= r_vi_p0;
      r_zero_p1 <= r_zero_p0;
    end
  end

  // Stage p2: floor shift, accumulate with v, reduce
  logic signed [SW-1:0] w_sr, w_si, w_vr, w_vi, w_tr, w_ti;
  assign w_sr = SW'(r_pr_p1 >>> FRAC);
  assign w_si = SW'(r_pi_p1 >>> FRAC);
  assign w_vr = SW'(r_vr_p1);
  assign w_vi = SW'(r_vi_p1);
  assign w_tr = i_op ? (w_vr - w_sr) : (w_vr + w_sr);
  assign w_ti = i_op ? (w_vi - w_si) : (w_vi + w_si);

  logic [EW-1:0] r_y_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_y_p2 <= '0;
    end else if (i_en) begin
      r_y_p2 <= r_zero_p1 ? '0 : {reduce_half(w_tr), reduce_half(w_ti)};
    end
  end

  assign o_y = r_y_p2;

endmodule

// File: rtl/complex_axpy_stream.sv
// Streaming complex AXPY: result = v +/- x'*c' over NI lanes per beat.
// Build option CAXPY_SAT_EN selects saturating instead of wrapping reduction.
module complex_axpy_stream
  import caxpy_pkg::*;
#(
  parameter int NI   = 8,
  parameter int EW   = CAXPY_EW,
  parameter int FRAC = 16,
  parameter int LW   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LW-1:0]      len,
  input  logic [EW-1:0]      constant,
  input  logic               op,
  input  logic [1:0]         conj_mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NI*EW-1:0]   first_row_input,
  input  logic [NI*EW-1:0]   second_row_input,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [NI*EW-1:0]   result,
  output logic               busy,
  output logic               finish
);

  localparam logic [LW:0] NI_W  = (LW+1)'(NI);
  localparam logic [LW:0] ONE_W = (LW+1)'(1);

  caxpy_state_t r_state, w_state_nxt;

  logic [LW-1:0] r_beats_total, r_tail, r_beats_in;
  logic [EW-1:0] r_const;
  logic          r_op;
  logic [1:0]    r_conj;
  logic          r_vld_p0, r_vld_p1, r_vld_p2;
  logic          r_last_p0, r_last_p1, r_last_p2;
  logic          r_finish;

  logic          w_adv, w_in_ready, w_accept, w_last_in, w_out_done, w_start_idle;
  logic [LW:0]   w_len_x, w_total_x, w_tail_x;

  assign w_len_x   = {1'b0, len};
  assign w_total_x = (w_len_x + NI_W - ONE_W) / NI_W;
  assign w_tail_x  = w_len_x - NI_W * (w_total_x - ONE_W);

  assign w_adv        = !r_vld_p2 | out_ready;
  assign w_in_ready   = (r_state == ST_RUN) & w_adv & (r_beats_in < r_beats_total);
  assign w_accept     = in_valid & w_in_ready;
  assign w_last_in    = (r_beats_in == (r_beats_total - LW'(1)));
  assign w_out_done   = r_vld_p2 & out_ready & r_last_p2;
  assign w_start_idle = start & (r_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start && (len != '0)) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_accept && w_last_in) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_out_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beats_total <= '0;
      r_tail        <= '0;
      r_beats_in    <= '0;
      r_vld_p0      <= 1'b0;
      r_vld_p1      <= 1'b0;
      r_vld_p2      <= 1'b0;
      r_last_p0     <= 1'b0;
      r_last_p1     <= 1'b0;
      r_last_p2     <= 1'b0;
      r_finish      <= 1'b0;
    end else begin
      // a zero-length request completes immediately without entering RUN
      r_finish <= (w_start_idle & (len == '0)) | w_out_done;
      if (w_start_idle) begin
        r_beats_total <= LW'(w_total_x);
        r_tail        <= LW'(w_tail_x);
        r_beats_in    <= '0;
      end else if (w_accept) begin
        r_beats_in <= r_beats_in + LW'(1);
      end
      if (w_adv) begin
        r_vld_p0  <= w_accept;
        r_last_p0 <= w_accept & w_last_in;
        r_vld_p1  <= r_vld_p0;
        r_last_p1 <= r_last_p0;
        r_vld_p2  <= r_vld_p1;
        r_last_p2 <= r_last_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_start_idle) begin
      r_const <= constant;
      r_op    <= op;
      r_conj  <= conj_mode;
    end
  end

  logic [NI*EW-1:0] w_result;

  for (genvar k = 0; k < NI; k++) begin : g_lane
    logic w_zero;
    assign w_zero = w_last_in & (LW'(k) >= r_tail);

    caxpy_lane #(
      .EW   (EW),
      .FRAC (FRAC)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_en     (w_adv),
      .i_op     (r_op),
      .i_conj_x (r_conj[0]),
      .i_conj_c (r_conj[1]),
      .i_zero   (w_zero),
      .i_x      (first_row_input[EW*(NI-k)-1 -: EW]),
      .i_c      (r_const),
      .i_v      (second_row_input[EW*(NI-k)-1 -: EW]),
      .o_y      (w_result[EW*(NI-k)-1 -: EW])
    );
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_vld_p2;
  assign out_last  = r_last_p2;
  assign result    = w_result;
  assign busy      = (r_state != ST_IDLE);
  assign finish    = r_finish;

endmodule
